// File: rtl/seq_divider.sv
// Sequential signed divider: 32-bit dividend by 16-bit divisor, one restoring
// step per cycle, saturating 16-bit quotient with overflow and zero-divisor flags.
module seq_divider (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [31:0] dividend,
  input  logic [15:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [15:0] quotient,
  output logic [15:0] remainder,
  output logic        div_by_zero,
  output logic        overflow
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    ITER = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam logic [31:0] POS_LIMIT = 32'd32767;
  localparam logic [31:0] NEG_LIMIT = 32'd32768;

  function automatic logic [32:0] abs33(input logic [32:0] v);
    logic [32:0] r;
    if (v[32]) begin
      r = 33'd0 - v;
    end else begin
      r = v;
    end
    return r;
  endfunction

  function automatic logic [16:0] abs17(input logic [16:0] v);
    logic [16:0] r;
    if (v[16]) begin
      r = 17'd0 - v;
    end else begin
      r = v;
    end
    return r;
  endfunction

  state_t      state_q,     state_d;
  logic [32:0] dvd_q,       dvd_d;
  logic [16:0] dvs_q,       dvs_d;
  logic [16:0] dvs_mag_q,   dvs_mag_d;
  logic        q_neg_q,     q_neg_d;
  logic        r_neg_q,     r_neg_d;
  logic [5:0]  cnt_q,       cnt_d;
  logic [16:0] prem_q,      prem_d;
  logic [31:0] qmag_q,      qmag_d;
  logic [15:0] quotient_q,  quotient_d;
  logic [15:0] remainder_q, remainder_d;
  logic        dbz_q,       dbz_d;
  logic        ovf_q,       ovf_d;
  logic        busy_q,      busy_d;
  logic        done_q,      done_d;

  logic [17:0] trial_s;
  logic        ge_s;
  logic [16:0] sub_s;
  logic [15:0] rem_fix_s;

  // Next-state and datapath computation for every FSM state
  always_comb begin
    state_d     = state_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    dvs_mag_d   = dvs_mag_q;
    q_neg_d     = q_neg_q;
    r_neg_d     = r_neg_q;
    cnt_d       = cnt_q;
    prem_d      = prem_q;
    qmag_d      = qmag_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    ovf_d       = ovf_q;

    // In ITER the upper dvd bit is zero, so bit 31 is the next magnitude bit
    trial_s   = {prem_q, dvd_q[31]};
    ge_s      = (trial_s >= {1'b0, dvs_mag_q});
    sub_s     = trial_s[16:0] - dvs_mag_q;
    if (r_neg_q) begin
      rem_fix_s = 16'd0 - prem_q[15:0];
    end else begin
      rem_fix_s = prem_q[15:0];
    end

    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = LOAD;
          dvd_d   = {dividend[31], dividend};
          dvs_d   = {divisor[15], divisor};
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        dvd_d     = abs33(dvd_q);
        dvs_mag_d = abs17(dvs_q);
        q_neg_d   = dvd_q[32] ^ dvs_q[16];
        r_neg_d   = dvd_q[32];
        cnt_d     = 6'd0;
        prem_d    = 17'd0;
        qmag_d    = 32'd0;
        // A zero divisor skips the iterations; FIX publishes the flag
        if (dvs_q == 17'd0) begin
          state_d = FIX;
        end else begin
          state_d = ITER;
        end
      end
      ITER: begin
        dvd_d = {dvd_q[31:0], 1'b0};
        if (ge_s) begin
          prem_d = sub_s;
          qmag_d = {qmag_q[30:0], 1'b1};
        end else begin
          prem_d = trial_s[16:0];
          qmag_d = {qmag_q[30:0], 1'b0};
        end
        if (cnt_q == 6'd31) begin
          state_d = FIX;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      FIX: begin
        state_d = DONE;
        if (dvs_mag_q == 17'd0) begin
          quotient_d  = 16'd0;
          remainder_d = 16'd0;
          dbz_d       = 1'b1;
          ovf_d       = 1'b0;
        end else if (q_neg_q) begin
          dbz_d = 1'b0;
          if (qmag_q > NEG_LIMIT) begin
            quotient_d  = 16'h8000;
            remainder_d = 16'd0;
            ovf_d       = 1'b1;
          end else begin
            quotient_d  = 16'd0 - qmag_q[15:0];
            remainder_d = rem_fix_s;
            ovf_d       = 1'b0;
          end
        end else begin
          dbz_d = 1'b0;
          if (qmag_q > POS_LIMIT) begin
            quotient_d  = 16'h7FFF;
            remainder_d = 16'd0;
            ovf_d       = 1'b1;
          end else begin
            quotient_d  = qmag_q[15:0];
            remainder_d = rem_fix_s;
            ovf_d       = 1'b0;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == LOAD) || (state_d == ITER) || (state_d == FIX);
    done_d = (state_d == DONE);
  end

  // State, datapath and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      dvd_q       <= 33'd0;
      dvs_q       <= 17'd0;
      dvs_mag_q   <= 17'd0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      cnt_q       <= 6'd0;
      prem_q      <= 17'd0;
      qmag_q      <= 32'd0;
      quotient_q  <= 16'd0;
      remainder_q <= 16'd0;
      dbz_q       <= 1'b0;
      ovf_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      dvs_mag_q   <= dvs_mag_d;
      q_neg_q     <= q_neg_d;
      r_neg_q     <= r_neg_d;
      cnt_q       <= cnt_d;
      prem_q      <= prem_d;
      qmag_q      <= qmag_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
      ovf_q       <= ovf_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

endmodule
